// File: rtl/ps2_mmio_hub.sv
// ps2_mmio_hub -- memory-mapped PS/2 keyboard hub.
// Receives PS/2 frames, validates start/parity/stop bits, queues scan codes in a
// FIFO and exposes them to the CPU through four registers at BASE_ADDR..+3:
//   +0 DATA   (R)  pop head, zero-extended (0 when empty)
//   +1 STATUS (R)  {irq_en, overflow, parity_err, full, not_empty}
//   +2 CTRL   (RW) bit0 irq_en, bit1 w1 clear flags, bit2 w1 flush
//   +3 COUNT  (R)  FIFO occupancy
// Ports: clk/reset_n (sync, active low); ps2_clk/ps2_dat raw async PS/2 lines;
//   cpu_addr/cpu_rd/cpu_wr/cpu_wdata bus in; cpu_rdata/cpu_rvalid read response
//   (latency 1); irq level (irq_en & not_empty, registered); key_code/key_valid
//   strobe per accepted code; overflow sticky flag.
// Optional build macro PS2_BREAK_FILTER_EN: folds the 0xF0 break prefix into
//   bit 8 of the following entry instead of storing it.
module ps2_mmio_hub #(
    parameter int                DATA_W      = 16,
    parameter int                ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 16'hFF00,
    parameter int                FIFO_DEPTH  = 8,
    parameter int                SYNC_STAGES = 2,
    parameter int                TIMEOUT_CYC = 50000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ps2_clk,
    input  logic              ps2_dat,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    output logic              irq,
    output logic [7:0]        key_code,
    output logic              key_valid,
    output logic              overflow
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
`ifdef PS2_BREAK_FILTER_EN
    localparam int ENT_W = 9;
`else
    localparam int ENT_W = 8;
`endif

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    state_t                 state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   par_q, par_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   parity_err_q, parity_err_d, overflow_q, overflow_d;
    logic                   irq_en_q, irq_en_d, irq_q, irq_d, brk_q, brk_d;
    logic [7:0]             key_code_q, key_code_d;
    logic                   key_valid_q, key_valid_d, rvalid_q, rvalid_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic [ENT_W-1:0]       mem_q [FIFO_DEPTH];

    logic              clk_s, dat_s, fall, accept, frame_err, tmo_hit;
    logic              push_req, fifo_we, pop, flush, clr_flags, full, not_empty;
    logic              rd_hit, wr_ctrl;
    logic [ADDR_W-1:0] offset;
    logic [ENT_W-1:0]  push_data;
    logic              wdata_unused;

    assign clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    assign dat_sync_d   = {dat_sync_q[SYNC_STAGES-2:0], ps2_dat};
    assign clk_s        = clk_sync_q[SYNC_STAGES-1];
    assign dat_s        = dat_sync_q[SYNC_STAGES-1];
    assign clk_prev_d   = clk_s;
    assign fall         = clk_prev_q & ~clk_s;
    assign wdata_unused = ^cpu_wdata[DATA_W-1:3];

    // Frame receiver: one step per falling PS/2 clock; idle time inside a
    // frame is bounded so a glitch or unplugged device cannot wedge it.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        tmo_d     = tmo_q;
        accept    = 1'b0;
        frame_err = 1'b0;
        tmo_hit   = 1'b0;
        if (fall) begin
            tmo_d = '0;
            case (state_q)
                S_IDLE: if (!dat_s) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                end
                S_DATA: begin
                    shift_d   = {dat_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: begin
                    par_d   = dat_s;
                    state_d = S_STOP;
                end
                default: begin
                    if (dat_s && (^{shift_q, par_q})) accept = 1'b1;
                    else                              frame_err = 1'b1;
                    state_d = S_IDLE;
                end
            endcase
        end else if (state_q != S_IDLE) begin
            tmo_d = tmo_q + 1'b1;
            if (tmo_d == TMO_W'(TIMEOUT_CYC)) begin
                state_d = S_IDLE;
                tmo_d   = '0;
                tmo_hit = 1'b1;
            end
        end
    end

    // CPU decode; a simultaneous write is dropped in favour of the read.
    assign offset    = cpu_addr - BASE_ADDR;
    assign rd_hit    = cpu_rd & (offset < ADDR_W'(4));
    assign wr_ctrl   = cpu_wr & ~cpu_rd & (offset == ADDR_W'(2));
    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign not_empty = (count_q != '0);
    assign pop       = rd_hit & (offset == '0) & not_empty;
    assign flush     = wr_ctrl & cpu_wdata[2];
    assign clr_flags = wr_ctrl & cpu_wdata[1];

`ifdef PS2_BREAK_FILTER_EN
    // 0xF0 only arms the flag; 0xE0 is an extended prefix and leaves it armed.
    assign push_req  = accept & (shift_q != 8'hF0);
    assign push_data = {brk_q & (shift_q != 8'hE0), shift_q};
    always_comb begin
        brk_d = brk_q;
        if (accept && shift_q == 8'hF0)        brk_d = 1'b1;
        else if (push_req && shift_q != 8'hE0) brk_d = 1'b0;
        if (flush || tmo_hit)                  brk_d = 1'b0;
    end
`else
    logic tmo_unused;
    assign tmo_unused = tmo_hit;
    assign push_req   = accept;
    assign push_data  = shift_q;
    assign brk_d      = 1'b0;
`endif

    // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
    always_comb begin
        fifo_we      = push_req & ~flush & (~full | pop);
        wr_ptr_d     = fifo_we ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d     = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d      = count_q + CNT_W'(fifo_we) - CNT_W'(pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
        parity_err_d = frame_err | (parity_err_q & ~clr_flags);
        overflow_d   = (push_req & ~flush & full & ~pop) | (overflow_q & ~clr_flags);
        irq_en_d     = wr_ctrl ? cpu_wdata[0] : irq_en_q;
        irq_d        = irq_en_q & not_empty;
        key_code_d   = push_req ? shift_q : key_code_q;
        key_valid_d  = push_req;
        rvalid_d     = rd_hit;
        rdata_d      = '0;
        if (rd_hit) begin
            case (offset[1:0])
                2'd0:    if (not_empty) rdata_d = DATA_W'(mem_q[rd_ptr_q]);
                2'd1:    rdata_d = DATA_W'({irq_en_q, overflow_q, parity_err_q, full, not_empty});
                2'd2:    rdata_d = DATA_W'(irq_en_q);
                default: rdata_d = DATA_W'(count_q);
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && fifo_we) mem_q[wr_ptr_q] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clk_sync_q   <= '1;
            dat_sync_q   <= '1;
            clk_prev_q   <= 1'b1;
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            tmo_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            parity_err_q <= 1'b0;
            overflow_q   <= 1'b0;
            irq_en_q     <= 1'b0;
            irq_q        <= 1'b0;
            brk_q        <= 1'b0;
            key_code_q   <= '0;
            key_valid_q  <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
        end else begin
            clk_sync_q   <= clk_sync_d;
            dat_sync_q   <= dat_sync_d;
            clk_prev_q   <= clk_prev_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            tmo_q        <= tmo_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            parity_err_q <= parity_err_d;
            overflow_q   <= overflow_d;
            irq_en_q     <= irq_en_d;
            irq_q        <= irq_d;
            brk_q        <= brk_d;
            key_code_q   <= key_code_d;
            key_valid_q  <= key_valid_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
        end
    end

    assign cpu_rdata  = rdata_q;
    assign cpu_rvalid = rvalid_q;
    assign irq        = irq_q;
    assign key_code   = key_code_q;
    assign key_valid  = key_valid_q;
    assign overflow   = overflow_q;
endmodule

// File: tb/tb_ps2_mmio_hub.sv
`timescale 1ns/1ps
module tb_ps2_mmio_hub;
    localparam int          DATA_W = 16;
    localparam int          ADDR_W = 16;
    localparam int          DEPTH  = 8;
    localparam int          TMO    = 300;
    localparam int          H      = 10;   // PS/2 half period in clk cycles
    localparam logic [15:0] BASE   = 16'hFF00;

    logic              clk, reset_n, ps2_clk, ps2_dat, cpu_rd, cpu_wr;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic              cpu_rvalid, irq, key_valid, overflow;
    logic [7:0]        key_code;

    ps2_mmio_hub #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BASE_ADDR(BASE),
        .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .irq(irq), .key_code(key_code), .key_valid(key_valid), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int cyc = 0, kv_cnt = 0, kv_cyc = 0, irq_rise_cyc = 0;
    logic irq_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (key_valid) begin
            kv_cnt = kv_cnt + 1;
            kv_cyc = cyc;
        end
        if (irq && !irq_prev) irq_rise_cyc = cyc;
        irq_prev = irq;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Frame bit order: start(0), 8 data LSB first, odd parity, stop(1).
    task automatic send_bits(input logic [7:0] b, input logic bad, input int nb);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad, b, 1'b0};
        for (int i = 0; i < nb; i++) begin
            ps2_dat = fr[i];
            tick(H);
            ps2_clk = 1'b0;
            tick(H);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
        tick(H);
    endtask

    task automatic send(input logic [7:0] b);
        send_bits(b, 1'b0, 11);
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] d, output logic v);
        cpu_addr = a;
        cpu_rd   = 1'b1;
        tick(1);
        cpu_rd   = 1'b0;
        d        = cpu_rdata;
        v        = cpu_rvalid;
    endtask

    task automatic chk_rd(input string tag, input logic [1:0] off, input logic [15:0] exp);
        logic [15:0] d;
        logic        v;
        rd(BASE + 16'(off), d, v);
        chk({tag, "_vld"}, 32'(v), 32'd1);
        chk(tag, 32'(d), 32'(exp));
    endtask

    task automatic wr_ctrl(input logic [15:0] d);
        cpu_addr  = BASE + 16'd2;
        cpu_wdata = d;
        cpu_wr    = 1'b1;
        tick(1);
        cpu_wr    = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        logic        v;
        int          kv0;
        clk = 0; reset_n = 0; ps2_clk = 1; ps2_dat = 1;
        cpu_rd = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
        tick(3);
        chk("rst_rvalid", 32'(cpu_rvalid), 0);
        chk("rst_rdata", 32'(cpu_rdata), 0);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_keycode", 32'(key_code), 0);
        chk("rst_ovf", 32'(overflow), 0);
        reset_n = 1;
        tick(2);
        chk_rd("rst_count", 2'd3, 16'h0000);
        chk_rd("rst_status", 2'd1, 16'h0000);

        // Single good frame
        send(8'h1C);
        chk("kv_once", 32'(kv_cnt), 1);
        chk("keycode_1c", 32'(key_code), 32'h1C);
        chk_rd("count_1", 2'd3, 16'd1);
        chk_rd("data_1c", 2'd0, 16'h001C);
        tick(1);
        chk("rvalid_pulse", 32'(cpu_rvalid), 0);
        chk_rd("status_empty", 2'd1, 16'h0000);

        // Bad parity
        send_bits(8'h1C, 1'b1, 11);
        chk("kv_badpar", 32'(kv_cnt), 1);
        chk_rd("status_perr", 2'd1, 16'h0004);
        wr_ctrl(16'h0002);
        chk_rd("status_clr", 2'd1, 16'h0000);

        // Overflow with 9 frames
        for (int i = 0; i < 9; i++) send(8'h10 + 8'(i));
        chk("kv_nine", 32'(kv_cnt), 10);
        chk_rd("count_full", 2'd3, 16'd8);
        chk_rd("status_ovf", 2'd1, 16'h000B);
        chk("ovf_pin", 32'(overflow), 1);
        for (int i = 0; i < 8; i++) chk_rd("fifo_order", 2'd0, 16'h10 + 16'(i));
        chk_rd("count_drain", 2'd3, 16'd0);
        chk_rd("data_empty", 2'd0, 16'h0000);
        wr_ctrl(16'h0002);

        // Full FIFO, frame completes on the same edge as a DATA pop
        for (int i = 0; i < 8; i++) send(8'h20 + 8'(i));
        send_bits(8'h28, 1'b0, 10);
        ps2_dat = 1'b1;
        tick(H);
        ps2_clk = 1'b0;
        tick(2);
        cpu_addr = BASE;
        cpu_rd   = 1'b1;
        tick(1);
        cpu_rd   = 1'b0;
        chk("sim_rvalid", 32'(cpu_rvalid), 1);
        chk("sim_data", 32'(cpu_rdata), 32'h20);
        chk("sim_kv", 32'(key_valid), 1);
        tick(H);
        ps2_clk = 1'b1;
        tick(H);
        chk_rd("sim_count", 2'd3, 16'd8);
        chk_rd("sim_status", 2'd1, 16'h0003);
        for (int i = 1; i <= 8; i++) chk_rd("sim_order", 2'd0, 16'h20 + 16'(i));

        // Abandoned partial frame then a full frame
        send_bits(8'h55, 1'b0, 4);
        tick(TMO + 20);
        send(8'h29);
        chk_rd("tmo_count", 2'd3, 16'd1);
        chk_rd("tmo_status", 2'd1, 16'h0001);
        chk_rd("tmo_data", 2'd0, 16'h0029);

        // Interrupt
        wr_ctrl(16'h0001);
        chk_rd("status_irqen", 2'd1, 16'h0010);
        send(8'h5A);
        chk("irq_lag", 32'(irq_rise_cyc), 32'(kv_cyc + 1));
        chk("irq_level", 32'(irq), 1);
        chk_rd("irq_data", 2'd0, 16'h005A);
        chk("irq_hold", 32'(irq), 1);
        tick(1);
        chk("irq_drop", 32'(irq), 0);

        // Address misses
        rd(16'hFF04, d, v);
        chk("miss_hi_vld", 32'(v), 0);
        chk("miss_hi_data", 32'(d), 0);
        rd(16'hFEFF, d, v);
        chk("miss_lo_vld", 32'(v), 0);

        // Read and write together: write is ignored
        cpu_addr = BASE + 16'd2; cpu_wdata = 16'h0000;
        cpu_rd = 1'b1; cpu_wr = 1'b1;
        tick(1);
        cpu_rd = 1'b0; cpu_wr = 1'b0;
        chk("rw_data", 32'(cpu_rdata), 1);
        chk_rd("rw_status", 2'd1, 16'h0010);

        // Flush
        send(8'h33);
        send(8'h34);
        chk_rd("pre_flush", 2'd3, 16'd2);
        wr_ctrl(16'h0005);
        chk_rd("post_flush", 2'd3, 16'd0);
        chk_rd("flush_status", 2'd1, 16'h0010);
        wr_ctrl(16'h0000);

        // Break prefix
        kv0 = kv_cnt;
        send(8'hF0);
        send(8'h1C);
`ifdef PS2_BREAK_FILTER_EN
        chk("brk_kv", 32'(kv_cnt), 32'(kv0 + 1));
        chk_rd("brk_count", 2'd3, 16'd1);
        chk_rd("brk_data", 2'd0, 16'h011C);
`else
        chk("brk_kv", 32'(kv_cnt), 32'(kv0 + 2));
        chk_rd("brk_count", 2'd3, 16'd2);
        chk_rd("brk_raw_f0", 2'd0, 16'h00F0);
        chk_rd("brk_raw_1c", 2'd0, 16'h001C);
`endif

        // Reset during a read suppresses the response
        send_bits(8'h44, 1'b1, 11);
        cpu_addr = BASE + 16'd1;
        cpu_rd   = 1'b1;
        reset_n  = 1'b0;
        tick(1);
        cpu_rd   = 1'b0;
        chk("rst_rd_vld", 32'(cpu_rvalid), 0);
        chk("rst_rd_data", 32'(cpu_rdata), 0);
        chk("rst_keycode2", 32'(key_code), 0);
        reset_n = 1'b1;
        tick(1);
        chk_rd("rst_status2", 2'd1, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ps2_mmio_hub.md
Name: ps2_mmio_hub

Overview:
- Memory-mapped keyboard I/O hub that lets the CPU read keystrokes through loads and stores.
- Receives PS/2 frames, checks them, and buffers scan codes in a parametrised FIFO.
- Exposes data, status, control and count registers at a configurable base address, with a level interrupt to the CPU.
- Also forwards each accepted code as a one-cycle strobe so the VGA side can consume keys without CPU involvement.

Parameters:
DATA_W, 16, CPU data bus width (>= 16)
ADDR_W, 16, CPU address width
BASE_ADDR, 16'hFF00, address of register 0; registers occupy BASE_ADDR..BASE_ADDR+3
FIFO_DEPTH, 8, scan-code FIFO entries; power of 2, 2..64
SYNC_STAGES, 2, flip-flop stages on ps2_clk/ps2_dat (>= 2)
TIMEOUT_CYC, 50000, idle clk cycles inside a frame before it is abandoned

Ports:
clk  in  1  system clock, 50 MHz
reset_n  in  1  synchronous, active-low reset
ps2_clk  in  1  raw PS/2 clock (asynchronous)
ps2_dat  in  1  raw PS/2 data (asynchronous)
cpu_addr  in  ADDR_W  CPU address
cpu_rd  in  1  read strobe, one cycle per access
cpu_wr  in  1  write strobe, one cycle per access
cpu_wdata  in  DATA_W  write data
cpu_rdata  out  DATA_W  registered read data
cpu_rvalid  out  1  one-cycle pulse, rdata valid
irq  out  1  registered interrupt level
key_code  out  8  last accepted scan code
key_valid  out  1  one-cycle pulse per accepted code
overflow  out  1  sticky FIFO overflow flag

Behaviour:
- Reset (clk edge with reset_n=0): FSM to IDLE; FIFO empty; irq_en=0; all flags cleared; all outputs 0; synchronisers preset to 1.
- Input path: both PS/2 lines pass through SYNC_STAGES flops. A sample event is a synchronised ps2_clk 1->0 transition.
- Frame FSM, one step per sample event:
  - IDLE: dat=0 -> DATA (bit counter 0); dat=1 -> ignored.
  - DATA: shift 8 bits LSB first -> PARITY.
  - PARITY: capture parity bit -> STOP.
  - STOP: dat=1 and odd parity correct -> push; otherwise set parity_err, discard. Return to IDLE.
- Timeout: counter clears on each sample event. Reaching TIMEOUT_CYC in any non-IDLE state -> IDLE, partial byte discarded, no flag set.
- Push: on accept, key_code updates and key_valid pulses in the same cycle as the FIFO write, independent of FIFO state.
- FIFO full on push: byte dropped, overflow set (sticky), contents unchanged.
- Register map (offset from BASE_ADDR):
  - +0 DATA (R): pops the head; rdata = zero-extended entry. If empty: rdata=0, no pop, no underflow effect.
  - +1 STATUS (R): bit0 not_empty, bit1 full, bit2 parity_err, bit3 overflow, bit4 irq_en; other bits 0.
  - +2 CTRL (R/W): bit0 irq_en (R/W); bit1 write-1 clears parity_err and overflow; bit2 write-1 flushes FIFO. Bits 1 and 2 read 0.
  - +3 COUNT (R): number of entries, 0..FIFO_DEPTH.
- Read timing: latency 1. cpu_rd and hit at cycle N -> cpu_rdata and cpu_rvalid=1 at N+1. Address miss -> no rvalid, rdata 0. Writes take effect at the next edge; no response.
- Simultaneous events:
  - Push and pop in the same cycle -> both occur, count unchanged. When full, the push is accepted because the pop frees a slot; no overflow.
  - Flush and push in the same cycle -> flush wins, byte discarded, key_valid still pulses.
  - Flag clear and flag set in the same cycle -> set wins.
  - cpu_rd and cpu_wr together -> write ignored, read served.
- Pointers: log2(FIFO_DEPTH) bits wrap modulo depth; separate count register, width log2(FIFO_DEPTH)+1.
- irq: registered as irq_en & not_empty; one-cycle lag after the condition changes.
- Reset mid-frame or mid-read: everything returns to reset state at that edge; a pending rvalid is suppressed.

Optional Feature:
PS2_BREAK_FILTER_EN
- Defined:
  - Byte 8'hF0 is not pushed; it arms a break flag instead.
  - The next accepted byte is pushed as a 9-bit entry with bit8=1 (DATA read returns bit8 set), and the flag is then cleared.
  - key_valid does not pulse for 8'hF0.
  - 8'hE0 passes through unchanged and does not disturb an armed flag.
  - Timeout and flush clear the flag.
- Undefined: FIFO is 8 bits wide, all bytes are stored raw, and DATA bit8 is always 0.

Test Plan:
- Frame 0x1C with correct odd parity -> key_valid pulse, key_code=0x1C. Read BASE+3 -> 1; read BASE+0 -> 0x001C with rvalid one cycle later; then STATUS bit0=0.
- Frame 0x1C with wrong parity -> no push, STATUS=0x0004. Write CTRL=0x0002 -> STATUS=0x0000.
- 9 frames with FIFO_DEPTH=8 -> COUNT=8, STATUS bits1 and 3 set. Reading 8 times returns the first 8 bytes in order; the 9th byte is lost.
- With FIFO full, frame completes in the same cycle as a DATA read -> COUNT stays 8, overflow stays 0, new byte is at the tail.
- Start bit plus 3 data bits, then a TIMEOUT_CYC gap, then a full frame 0x29 -> only 0x29 stored.
- Write CTRL=0x0001, push 0x5A -> irq=1 one cycle after the push; read DATA -> irq=0 next cycle.
- PS2_BREAK_FILTER_EN defined: frames F0 then 1C -> COUNT=1, DATA read = 0x011C.
